imm_ext_stage: RTL and testbench
================================

# imm_ext_stage

Parametrised, pipelined immediate extender for the MIPS datapath. It accepts an IN_W-bit instruction immediate with a 2-bit extension mode and produces an OUT_W-bit operand in one of four forms: zero-extended, sign-extended, upper-placed (LUI) or branch offset. The result is registered behind a valid/ready handshake with a 2-entry skid buffer. It sits between decode and the ALU-B / branch-target operand muxes and replaces the fixed 16→32 zero-extender.

## Interface
Parameters:
- IN_W, 16, immediate width
- OUT_W, 32, result width; must satisfy OUT_W ≥ IN_W+2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of buffered results (pipeline flush)
- in_valid  in  1  immediate/mode presented
- in_ready  out  1  block can accept this cycle
- in_imm  in  IN_W  raw immediate field
- in_mode  in  2  extension mode
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  OUT_W  extended result

## Operation
- Mode 00 ZERO: {(OUT_W-IN_W) zeros, imm}.
- Mode 01 SIGN: {(OUT_W-IN_W) copies of imm[IN_W-1], imm}.
- Mode 10 UPPER: {imm, (OUT_W-IN_W) zeros}.
- Mode 11 BRANCH: sign-extend to OUT_W, then shift left 2; the top 2 bits are discarded.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage is a main register (drives out_data) and a skid register. Occupancy FSM: EMPTY, ONE, TWO.
  - EMPTY: accept → ONE (main ← ext(in)).
  - ONE: accept & !pop → TWO (skid ← ext(in)). Pop & !accept → EMPTY. Accept & pop → ONE (main ← ext(in)).
  - TWO: no accept possible. Pop → ONE (main ← skid).
- in_ready = (state != TWO), decoded from state only. There is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY).
- flush: next state EMPTY and all held data is discarded. flush overrides an accept or pop in the same cycle, and the flushed input is not stored.
- out_data holds its value while out_valid=1 and out_ready=0.
- Results leave in strict acceptance order: no loss, no duplication.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, out_valid 0, out_data 0, skid 0, in_ready 1. in_valid is ignored while rst_n is low. Deassertion is synchronised externally.
- Latency: an item accepted at edge N is on out_data with out_valid=1 from just after edge N.
- Throughput: 1 result/cycle when out_ready is held high.
- in_ready drops the cycle after the second unpopped accept.
- in_ready rises the cycle after a pop in TWO, or after a flush.
- Reset or flush mid-stream: all in-flight results are lost. out_valid is low from the next cycle (immediately for reset).
- The mode is sampled with the immediate at accept. A later change of in_mode has no effect on stored results.

## Structure
- Package ext_pkg holds the mode constants: EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11.
- Package ext_pkg also holds the occupancy state encoding: EMPTY/ONE/TWO.
- One combinational sub-module, imm_ext_core (IN_W, OUT_W, imm, mode → ext), is instantiated once on the input side. The skid register therefore stores extended data.
- The parent imm_ext_stage holds the FSM, the main and skid registers, and the handshake logic.

## Test plan
- Mode coverage (IN_W16/OUT_W32, out_ready=1):
  - ZERO 0x8001 → 0x00008001.
  - SIGN 0x8001 → 0xFFFF8001.
  - SIGN 0x7FFF → 0x00007FFF.
  - UPPER 0x1234 → 0x12340000.
  - BRANCH 0xFFFF → 0xFFFFFFFC.
  - BRANCH 0x0004 → 0x00000010.
- Back-to-back stream: 8 accepts with out_ready=1 → 8 consecutive out_valid cycles, one cycle after each accept, in order.
- Backpressure: out_ready=0; push A=0x0001 SIGN, B=0x8000 SIGN, offer C.
  - in_ready goes 0 after B; C is held.
  - Raise out_ready → outputs 0x00000001, 0xFFFF8000, then C, with no gaps beyond one cycle and no duplicates.
- Simultaneous accept+pop in ONE: state stays ONE and out_data updates to the new item the next cycle.
- Flush in TWO, with in_valid high the same cycle → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Async reset asserted mid-stream (between clock edges) → out_valid=0 and out_data=0 immediately; normal operation resumes after release.
- Second parametrisation IN_W=12/OUT_W=20: SIGN 0x800 → 0xFF800; BRANCH 0xFFF → 0xFFFFC.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender: extension mode codes and
// the occupancy states of the output skid buffer.
package ext_pkg;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign, upper-placed or
// branch-offset (sign-extended, shifted left by two) forms.
module imm_ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    ext  = sext;
    case (mode)
      EXT_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_SIGN:   ext = sext;
      EXT_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:    ext = sext;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate extender behind a valid/ready handshake with a
// two-entry skid buffer; in_ready depends on occupancy state only.
module imm_ext_stage
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  occ_state_t       state, state_next;
  logic [OUT_W-1:0] main_q, main_next;
  logic [OUT_W-1:0] skid_q, skid_next;
  logic [OUT_W-1:0] ext;
  logic             accept, pop;

  // Extension happens before storage, so the skid register holds final data.
  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext)
  );

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

  // Flush wins over any accept or pop in the same cycle.
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = ext;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_next = TWO;
            skid_next  = ext;
          end else if (pop && !accept) begin
            state_next = EMPTY;
          end else if (accept && pop) begin
            main_next = ext;
          end
        end
        TWO: begin
          if (pop) begin
            state_next = ONE;
            main_next  = skid_q;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Randomised scoreboard bench for imm_ext_stage, plus directed checks of
// both parametrisations.
module tb_imm_ext_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  logic        flush2;
  logic        in_valid2;
  logic        in_ready2;
  logic [11:0] in_imm2;
  logic [1:0]  in_mode2;
  logic        out_valid2;
  logic        out_ready2;
  logic [19:0] out_data2;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] expq[$];

  imm_ext_stage #(.IN_W(16), .OUT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  imm_ext_stage #(.IN_W(12), .OUT_W(20)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2), .in_mode(in_mode2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the four forms computed arithmetically on a signed value.
  function automatic logic [31:0] refExt(input logic [15:0] imm, input logic [1:0] mode);
    longint sv;
    longint r;
    sv = imm[15] ? longint'(imm) - 65536 : longint'(imm);
    case (mode)
      2'd0:    r = longint'(imm);
      2'd1:    r = sv;
      2'd2:    r = longint'(imm) * 65536;
      default: r = sv * 4;
    endcase
    return r[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Holds the item on the input until accepted, then records its expected result.
  task automatic applyStimulus(input logic [15:0] imm, input logic [1:0] mode, input bit checkNow);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    @(negedge clk);
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: in_ready %b, expected 1", in_ready);
    end else begin
      expq.push_back(refExt(imm, mode));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (checkNow) begin
      checkOutput("latency_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("latency_data", out_data, refExt(imm, mode));
    end
  endtask

  task automatic drain();
    int waitCycles = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && waitCycles < 40) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic applyNarrow(input logic [11:0] imm, input logic [1:0] mode, input logic [19:0] expected);
    in_valid2 = 1'b1;
    in_imm2   = imm;
    in_mode2  = mode;
    @(negedge clk);
    checkOutput("narrow_ready", {31'b0, in_ready2}, 32'd1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    checkOutput("narrow_valid", {31'b0, out_valid2}, 32'd1);
    checkOutput("narrow_data", {12'b0, out_data2}, {12'b0, expected});
  endtask

  // Monitor: pops the scoreboard on every transfer the DUT presents.
  initial begin
    logic [31:0] expected;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (flush) begin
          expq.delete();
        end else if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_output: got %h, expected no output", out_data);
          end else begin
            expected = expq.pop_front();
            checkOutput("sb_data", out_data, expected);
          end
        end
      end
    end
  end

  logic [15:0] dirImm  [6] = '{16'h8001, 16'h8001, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0004};
  logic [1:0]  dirMode [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
  logic [31:0] dirExp  [6] = '{32'h00008001, 32'hFFFF8001, 32'h00007FFF,
                               32'h12340000, 32'hFFFFFFFC, 32'h00000010};
  bit randDone;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
    flush2 = 1'b0; in_valid2 = 1'b0; in_imm2 = '0; in_mode2 = '0; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] mode coverage");
    for (int i = 0; i < 6; i++) begin
      checkOutput("model_vs_table", refExt(dirImm[i], dirMode[i]), dirExp[i]);
      applyStimulus(dirImm[i], dirMode[i], 1'b1);
      checkOutput("mode_table", out_data, dirExp[i]);
    end
    drain();

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 8; i++)
      applyStimulus(16'($urandom), 2'($urandom), 1'b1);
    drain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(16'h0001, 2'b01, 1'b0);
    applyStimulus(16'h8000, 2'b01, 1'b0);
    checkOutput("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    fork
      applyStimulus(16'h0123, 2'b10, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("bp_hold_data", out_data, 32'h00000001);
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] flush in TWO and in ONE");
    for (int n = 2; n >= 1; n--) begin
      out_ready = 1'b0;
      for (int k = 0; k < n; k++)
        applyStimulus(16'($urandom), 2'($urandom), 1'b0);
      in_valid = 1'b1; in_imm = 16'hDEAD; in_mode = 2'b01; flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end

    $display("[TB] async reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(16'h4321, 2'b00, 1'b0);
    applyStimulus(16'hBEEF, 2'b11, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("areset_out_data", out_data, 32'd0);
    checkOutput("areset_in_ready", {31'b0, in_ready}, 32'd1);
    expq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(16'h00FF, 2'b10, 1'b1);
    drain();

    $display("[TB] randomised traffic with random backpressure");
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          applyStimulus(16'($urandom), 2'($urandom), 1'b0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom);
        end
      end
    join
    drain();

    $display("[TB] narrow parametrisation");
    applyNarrow(12'h800, 2'b01, 20'hFF800);
    applyNarrow(12'hFFF, 2'b11, 20'hFFFFC);
    applyNarrow(12'hABC, 2'b00, 20'h00ABC);
    applyNarrow(12'hABC, 2'b10, 20'hABC00);
    applyNarrow(12'h7FF, 2'b11, 20'h01FFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
